// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} pipe_state_e;

    localparam int IF_ID   = 1;
    localparam int ID_EX   = 2;
    localparam int EX_MEM  = 3;
    localparam int MEM_WB  = 4;
    localparam int MAX_BND = 16;

    // Bit i-1 of reg_en/reg_clr controls boundary i; upper bits unused for short pipes.
    typedef struct packed {
        logic               pc_en;
        logic [MAX_BND-1:0] reg_en;
        logic [MAX_BND-1:0] reg_clr;
    } pipe_ctrl_out_t;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter used for the performance counters.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: PC enable, per-boundary load/clear, valid tracking,
// memory-wait/halt sequencing and saturating perf counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_STAGES  = 5,
    parameter int FLUSH_DEPTH = 2,
    parameter int MEM_STAGE   = 3,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hazard_stall,
    input  logic                  redirect,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    input  logic                  halt_req,
    input  logic                  resume,
    output logic                  pc_en,
    output logic [NUM_STAGES-2:0] reg_en,
    output logic [NUM_STAGES-2:0] reg_clr,
    output logic [NUM_STAGES-2:0] stage_vld,
    output logic                  halted,
    output logic                  mem_timeout,
    output logic [CNT_WIDTH-1:0]  cyc_cnt,
    output logic [CNT_WIDTH-1:0]  ret_cnt,
    output logic [CNT_WIDTH-1:0]  stall_cnt,
    output logic [CNT_WIDTH-1:0]  flush_cnt
);
    localparam int NB = NUM_STAGES - 1;
    localparam int WW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    pipe_state_e    state;
    pipe_ctrl_out_t ctrl;
    logic           mem_wait, fetch_on, take_redir, take_haz, all_empty;
    logic [WW-1:0]  wait_cnt;

    assign mem_wait   = stage_vld[MEM_STAGE-1] & mem_req & ~mem_ready;
    assign fetch_on   = (state == RUN) || (state == MEM_WAIT);
    assign take_redir = ~mem_wait & redirect;
    assign take_haz   = ~mem_wait & ~redirect & hazard_stall;
    assign all_empty  = ~|stage_vld;

    always_comb begin
        ctrl = '0;
        if (rst) begin
            ctrl.reg_clr[NB-1:0] = '1;
        end else begin
            ctrl.pc_en           = fetch_on;
            ctrl.reg_en[NB-1:0]  = '1;
            // EX is frozen during a wait, so redirect/hazard re-present afterwards.
            if (mem_wait) begin
                ctrl.pc_en                  = 1'b0;
                ctrl.reg_en[MEM_STAGE-1:0]  = '0;
                ctrl.reg_clr[MEM_STAGE]     = 1'b1;
            end else if (redirect) begin
                ctrl.reg_clr[FLUSH_DEPTH-1:0] = '1;
            end else if (hazard_stall) begin
                ctrl.pc_en              = 1'b0;
                ctrl.reg_en[IF_ID-1]    = 1'b0;
                ctrl.reg_clr[ID_EX-1]   = 1'b1;
            end
            if (!fetch_on)
                ctrl.reg_clr[IF_ID-1] = 1'b1;
        end
    end

    assign pc_en   = ctrl.pc_en;
    assign reg_en  = ctrl.reg_en[NB-1:0];
    assign reg_clr = ctrl.reg_clr[NB-1:0];
    assign halted  = ~rst & ((state == HALTED) |
                             ((state == DRAIN) & all_empty & ~mem_wait));

    generate
        if (NB < MAX_BND) begin : g_unused
            logic unused_hi;
            assign unused_hi = ^{ctrl.reg_en[MAX_BND-1:NB], ctrl.reg_clr[MAX_BND-1:NB]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_vld <= '0;
        end else begin
            if (reg_clr[0])     stage_vld[0] <= 1'b0;
            else if (reg_en[0]) stage_vld[0] <= pc_en;
            for (int i = 1; i < NB; i++) begin
                if (reg_clr[i])     stage_vld[i] <= 1'b0;
                else if (reg_en[i]) stage_vld[i] <= stage_vld[i-1];
            end
        end
    end

    // MEM_WAIT exits once the wait condition is gone, so a dropped request cannot strand it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:      if (mem_wait) state <= MEM_WAIT;
                          else if (halt_req) state <= DRAIN;
                MEM_WAIT: if (!mem_wait) state <= halt_req ? DRAIN : RUN;
                DRAIN:    if (all_empty && !mem_wait) state <= HALTED;
                HALTED:   if (resume) state <= RUN;
                default:  state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else if (mem_wait) begin
            if ((MEM_TIMEOUT > 0) && (wait_cnt != WW'(MEM_TIMEOUT)))
                wait_cnt <= wait_cnt + WW'(1);
            if ((MEM_TIMEOUT > 0) && (wait_cnt == WW'(MEM_TIMEOUT - 1)))
                mem_timeout <= 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    sat_counter #(.W(CNT_WIDTH)) u_cyc   (.clk(clk), .rst(rst), .inc(1'b1),                 .cnt(cyc_cnt));
    sat_counter #(.W(CNT_WIDTH)) u_ret   (.clk(clk), .rst(rst), .inc(stage_vld[NB-1]),      .cnt(ret_cnt));
    sat_counter #(.W(CNT_WIDTH)) u_stall (.clk(clk), .rst(rst), .inc(mem_wait | take_haz),  .cnt(stall_cnt));
    sat_counter #(.W(CNT_WIDTH)) u_flush (.clk(clk), .rst(rst), .inc(take_redir),           .cnt(flush_cnt));

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a per-cycle behavioural model.
module tb_pipe_ctrl;
    localparam int NS = 5, FD = 2, MS = 3, MT = 4, CW = 8;
    localparam int NB = NS - 1;
    localparam longint CMAX = (64'd1 << CW) - 1;
    localparam int ADV = 0, HOLD = 1, CLR = 2;

    logic clk = 1'b0;
    logic rst, hazard_stall, redirect, mem_req, mem_ready, halt_req, resume;
    logic pc_en, halted, mem_timeout;
    logic [NB-1:0] reg_en, reg_clr, stage_vld;
    logic [CW-1:0] cyc_cnt, ret_cnt, stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    pipe_ctrl #(.NUM_STAGES(NS), .FLUSH_DEPTH(FD), .MEM_STAGE(MS),
                .MEM_TIMEOUT(MT), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .hazard_stall(hazard_stall), .redirect(redirect),
        .mem_req(mem_req), .mem_ready(mem_ready), .halt_req(halt_req), .resume(resume),
        .pc_en(pc_en), .reg_en(reg_en), .reg_clr(reg_clr), .stage_vld(stage_vld),
        .halted(halted), .mem_timeout(mem_timeout), .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: mode 0 = fetching, 1 = draining, 2 = halted.
    bit     mv [1:NB];
    int     act [1:NB];
    int     mode = 0, wcnt = 0;
    bit     m_to = 0, m_known = 0, mw, empty, e_pc, e_halt;
    longint m_cyc = 0, m_ret = 0, m_stall = 0, m_flush = 0;
    logic [NB-1:0] e_en, e_clr, e_vld;

    function automatic longint sat(input longint v);
        return (v > CMAX) ? CMAX : v;
    endfunction

    always @(negedge clk) begin
        mw    = mv[MS] && mem_req && !mem_ready;
        empty = 1;
        for (int i = 1; i <= NB; i++) begin
            act[i] = ADV;
            if (mv[i]) empty = 0;
            e_vld[i-1] = mv[i];
        end
        e_pc = (mode == 0);
        if (mw) begin
            e_pc = 0;
            for (int i = 1; i <= MS; i++) act[i] = HOLD;
            act[MS+1] = CLR;
        end else if (redirect) begin
            for (int i = 1; i <= FD; i++) act[i] = CLR;
        end else if (hazard_stall) begin
            e_pc = 0; act[1] = HOLD; act[2] = CLR;
        end
        if (mode != 0) act[1] = CLR;
        for (int i = 1; i <= NB; i++) begin
            e_en[i-1]  = (act[i] != HOLD);
            e_clr[i-1] = (act[i] == CLR);
        end
        e_halt = (mode == 2) || (mode == 1 && empty && !mw);
        if (rst) begin
            e_pc = 0; e_en = '0; e_clr = '1; e_halt = 0;
        end

        chk("m_pc_en", pc_en, e_pc);
        chk("m_reg_en", reg_en, e_en);
        chk("m_reg_clr", reg_clr, e_clr);
        chk("m_halted", halted, e_halt);
        if (m_known) begin
            chk("m_stage_vld", stage_vld, e_vld);
            chk("m_timeout", mem_timeout, m_to);
            chk("m_cyc", cyc_cnt, m_cyc);
            chk("m_ret", ret_cnt, m_ret);
            chk("m_stall", stall_cnt, m_stall);
            chk("m_flush", flush_cnt, m_flush);
        end

        if (rst) begin
            for (int i = 1; i <= NB; i++) mv[i] = 0;
            mode = 0; wcnt = 0; m_to = 0; m_known = 1;
            m_cyc = 0; m_ret = 0; m_stall = 0; m_flush = 0;
        end else begin
            m_cyc = sat(m_cyc + 1);
            if (mv[NB]) m_ret = sat(m_ret + 1);
            if (mw || (!redirect && hazard_stall)) m_stall = sat(m_stall + 1);
            if (!mw && redirect) m_flush = sat(m_flush + 1);
            for (int i = NB; i >= 1; i--) begin
                if (act[i] == CLR)      mv[i] = 0;
                else if (act[i] == ADV) mv[i] = (i == 1) ? e_pc : mv[i-1];
            end
            if (mode == 0 && !mw && halt_req)     mode = 1;
            else if (mode == 1 && empty && !mw)   mode = 2;
            else if (mode == 2 && resume)         mode = 0;
            if (mw) begin
                wcnt++;
                if (wcnt == MT) m_to = 1;
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int fill [4] = '{1, 3, 7, 15};

    initial begin
        rst = 1; hazard_stall = 0; redirect = 0; mem_req = 0;
        mem_ready = 0; halt_req = 0; resume = 0;
        cyc(); cyc();
        #1;
        chk("rst_pc_en", pc_en, 0);
        chk("rst_reg_clr", reg_clr, 4'b1111);
        chk("rst_vld", stage_vld, 0);
        rst = 0;

        // free run
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (k <= 4) chk("fill_vld", stage_vld, fill[k-1]);
        end
        chk("run_cyc", cyc_cnt, 10);
        chk("run_ret", ret_cnt, 6);

        // load-use stall
        hazard_stall = 1; #1;
        chk("haz_pc_en", pc_en, 0);
        chk("haz_reg_en", reg_en, 4'b1110);
        chk("haz_reg_clr", reg_clr, 4'b0010);
        cyc(); hazard_stall = 0;
        chk("haz_stall", stall_cnt, 1);
        chk("haz_vld0", stage_vld, 4'b1101);
        cyc(); cyc();
        chk("haz_bubble", stage_vld, 4'b0111);

        // redirect, then redirect+hazard
        redirect = 1; #1;
        chk("red_clr", reg_clr, 4'b0011);
        chk("red_pc_en", pc_en, 1);
        cyc(); chk("red_flush", flush_cnt, 1);
        hazard_stall = 1; #1;
        chk("redhaz_clr", reg_clr, 4'b0011);
        chk("redhaz_pc_en", pc_en, 1);
        cyc(); redirect = 0; hazard_stall = 0;
        chk("redhaz_flush", flush_cnt, 2);
        chk("redhaz_stall", stall_cnt, 1);

        // memory wait with redirect held
        repeat (4) cyc();
        mem_req = 1; redirect = 1; #1;
        chk("mw_pc_en", pc_en, 0);
        chk("mw_reg_en", reg_en, 4'b1000);
        chk("mw_reg_clr", reg_clr, 4'b1000);
        repeat (3) cyc();
        chk("mw_stall", stall_cnt, 4);
        chk("mw_flush", flush_cnt, 2);
        chk("mw_vld", stage_vld, 4'b0111);
        mem_ready = 1; #1;
        chk("mwr_clr", reg_clr, 4'b0011);
        chk("mwr_pc_en", pc_en, 1);
        cyc();
        chk("mwr_flush", flush_cnt, 3);
        mem_req = 0; mem_ready = 0; redirect = 0;
        chk("mw_no_to", mem_timeout, 0);

        // timeout
        mem_req = 1;
        repeat (3) cyc();
        chk("to_pre", mem_timeout, 0);
        cyc();
        chk("to_set", mem_timeout, 1);
        chk("to_stall", stall_cnt, 8);
        cyc(); cyc();
        mem_ready = 1; cyc();
        mem_req = 0; mem_ready = 0; cyc();
        chk("to_sticky", mem_timeout, 1);
        chk("to_stall2", stall_cnt, 10);
        rst = 1; cyc();
        chk("to_rst", mem_timeout, 0);
        chk("to_rst_vld", stage_vld, 0);
        chk("to_rst_cyc", cyc_cnt, 0);
        rst = 0;

        // halt / drain / resume
        repeat (4) cyc();
        chk("h_full", stage_vld, 4'b1111);
        halt_req = 1; #1;
        chk("h_req_pc_en", pc_en, 1);
        cyc(); halt_req = 0;
        chk("h_ret0", ret_cnt, 1);
        #1;
        chk("dr_pc_en", pc_en, 0);
        chk("dr_clr", reg_clr, 4'b0001);
        chk("dr_halted", halted, 0);
        repeat (4) cyc();
        chk("dr_empty", stage_vld, 0);
        chk("dr_ret", ret_cnt, 5);
        chk("dr_halted1", halted, 1);
        cyc();
        chk("hl_halted", halted, 1);
        resume = 1; #1;
        chk("hl_pc_en", pc_en, 0);
        cyc(); resume = 0; #1;
        chk("res_pc_en", pc_en, 1);
        repeat (2) cyc();
        halt_req = 1; cyc(); halt_req = 0;
        cyc();
        rst = 1; cyc(); rst = 0; #1;
        chk("rdr_pc_en", pc_en, 1);
        chk("rdr_vld", stage_vld, 0);

        // saturation
        repeat (300) cyc();
        chk("sat_cyc", cyc_cnt, CMAX);
        chk("sat_ret", ret_cnt, CMAX);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
